multicycle_state_ctrl: RTL and testbench

Clocked, parametrised instruction-state controller for the multi-cycle CPU control unit. It replaces the level-triggered next-state table with a registered FSM and adds three capabilities:
- memory-ready handshakes;
- a configurable multi-cycle multiplier wait;
- a global stall.

It sits in CU between the instruction register decode (op/funct) and the control-signal generator, which consumes `state`.

---
 rtl/multicycle_state_ctrl_if.sv | 40 ++++
 rtl/multicycle_state_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_state_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_state_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_state_ctrl_if
//
// Connects the instruction-register decode side to the instruction-state
// controller of the multi-cycle CPU control unit.
//
// Signals:
//   op         [5:0]  opcode of the instruction register        (decode -> ctrl)
//   funct      [5:0]  R-type function field                     (decode -> ctrl)
//   mem_ready         memory finished the current access        (decode -> ctrl)
//   stall             freeze the controller                     (decode -> ctrl)
//   state      [3:0]  current controller state, registered      (ctrl -> decode)
//   mul_start         one-cycle multiplier start pulse          (ctrl -> decode)
//   instr_done        one-cycle instruction-retired pulse       (ctrl -> decode)
//   illegal           one-cycle undecodable-instruction pulse   (ctrl -> decode)
//
// Modports:
//   master : the side that drives op/funct/mem_ready/stall (decode, bench)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface multicycle_state_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       stall;
    logic [3:0] state;
    logic       mul_start;
    logic       instr_done;
    logic       illegal;

    modport master (
        output op, funct, mem_ready, stall,
        input  state, mul_start, instr_done, illegal
    );

    modport slave (
        input  op, funct, mem_ready, stall,
        output state, mul_start, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_state_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_state_ctrl
//
// Registered instruction-state FSM for the multi-cycle CPU control unit.
// Handles memory-ready handshakes in IF/MEMLW/MEMSW, a MUL_LAT-cycle
// multiplier wait in MULW, and a global stall that freezes the FSM.
//
// Parameters:
//   MUL_LAT  cycles spent in MULW (legal 1 .. 2**CNT_W-1), default 3
//   CNT_W    width of the multiplier wait counter, default 4
//
// Ports:
//   trigger  clock, rising edge
//   rst      asynchronous active-high reset
//   bus      multicycle_state_ctrl_if.slave
//              in : op, funct, mem_ready, stall
//              out: state, mul_start, instr_done, illegal (all registered)
//
// Optional feature (macro ISC_TRAP_EN):
//   defined   : undecodable instructions in ID go to TRAP, 'illegal' pulses
//               for the TRAP cycle and the following IF does not report
//               instr_done.
//   undefined : TRAP is unreachable, undecodable instructions return to IF
//               and 'illegal' is tied low.
// ---------------------------------------------------------------------------
module multicycle_state_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                    trigger,
    input  logic                    rst,
    multicycle_state_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_IF    = 4'd1,
        S_ID    = 4'd2,
        S_EXER  = 4'd3,
        S_WBR   = 4'd4,
        S_EXEI  = 4'd5,
        S_WBI   = 4'd6,
        S_EXEB  = 4'd7,
        S_EXEW  = 4'd8,
        S_MEMLW = 4'd9,
        S_WBLW  = 4'd10,
        S_MEMSW = 4'd11,
        S_WBJAR = 4'd12,
        S_MULW  = 4'd13,
        S_TRAP  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 32'd1);

    // Where an undecodable instruction goes depends on whether trapping is built in.
`ifdef ISC_TRAP_EN
    localparam state_t S_BAD = S_TRAP;
`else
    localparam state_t S_BAD = S_IF;
`endif

    // R-type funct codes that execute in the ALU (jr is handled separately).
    function automatic logic is_alu_funct(input logic [5:0] f);
        case (f)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07:
                is_alu_funct = 1'b1;
            default:
                is_alu_funct = 1'b0;
        endcase
    endfunction

    // I-type ALU opcodes.
    function automatic logic is_itype_op(input logic [5:0] o);
        case (o)
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B:
                is_itype_op = 1'b1;
            default:
                is_itype_op = 1'b0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_q, mul_d;
    logic             mul_start_q, mul_start_d;
    logic             instr_done_q, instr_done_d;
    logic             illegal_q, illegal_d;

    // Next-state decode, counter/mul-flag updates and pulse conditions for an unstalled edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;

        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                if (bus.mem_ready) state_d = S_ID;
                else               state_d = S_IF;
            end
            S_ID: begin
                mul_d = (bus.op == OP_MUL);
                if (bus.op == OP_RTYPE) begin
                    if (is_alu_funct(bus.funct))  state_d = S_EXER;
                    else if (bus.funct == FN_JR)  state_d = S_IF;
                    else                          state_d = S_BAD;
                end else if (is_itype_op(bus.op)) begin
                    state_d = S_EXEI;
                end else begin
                    case (bus.op)
                        OP_BEQ, OP_BNE: state_d = S_EXEB;
                        OP_LW, OP_SW:   state_d = S_EXEW;
                        OP_JAL:         state_d = S_WBJAR;
                        OP_J:           state_d = S_IF;
                        OP_MUL:         state_d = S_EXER;
                        default:        state_d = S_BAD;
                    endcase
                end
            end
            S_EXER: begin
                if (mul_q) begin
                    state_d = S_MULW;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_WBR;
                end
            end
            S_MULW: begin
                // Counter runs MUL_LAT-1 .. 0, giving exactly MUL_LAT cycles in MULW.
                if (cnt_q == '0) state_d = S_WBR;
                else             cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            S_EXEI: state_d = S_WBI;
            S_EXEW: begin
                if (bus.op == OP_LW)      state_d = S_MEMLW;
                else if (bus.op == OP_SW) state_d = S_MEMSW;
                else                      state_d = S_BAD;
            end
            S_MEMLW: begin
                if (bus.mem_ready) state_d = S_WBLW;
                else               state_d = S_MEMLW;
            end
            S_MEMSW: begin
                if (bus.mem_ready) state_d = S_IF;
                else               state_d = S_MEMSW;
            end
            S_WBR, S_WBI, S_EXEB, S_WBLW, S_WBJAR, S_TRAP: state_d = S_IF;
            default: state_d = S_IF;
        endcase

        // The mul flag belongs to one instruction only.
        if (state_d == S_IF) mul_d = 1'b0;
        else                 mul_d = mul_d;

        mul_start_d  = (state_q == S_ID) && (state_d == S_EXER) && mul_d;
        // Retirement is reported on arrival in IF, except after reset and after a trap.
        instr_done_d = (state_d == S_IF) && (state_q != S_INIT) &&
                       (state_q != S_IF) && (state_q != S_TRAP);
`ifdef ISC_TRAP_EN
        illegal_d    = (state_d == S_TRAP);
`else
        illegal_d    = 1'b0;
`endif
    end

    // State, counter, mul flag and pulse registers; a stall freezes the FSM and blanks the pulses.
    always_ff @(posedge trigger or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            mul_q        <= 1'b0;
            mul_start_q  <= 1'b0;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (bus.stall) begin
            mul_start_q  <= 1'b0;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_q        <= mul_d;
            mul_start_q  <= mul_start_d;
            instr_done_q <= instr_done_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.instr_done = instr_done_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_state_ctrl
//
// Random instruction stream, random mem_ready/stall and occasional
// asynchronous resets, compared every cycle against a reference model that
// expands each decoded instruction into the list of states it must visit.
// ---------------------------------------------------------------------------
module tb_multicycle_state_ctrl;

    localparam int L      = 3;
    localparam int NCYC   = 4000;

    localparam int S_INIT = 0,  S_IF   = 1,  S_ID    = 2,  S_EXER  = 3;
    localparam int S_WBR  = 4,  S_EXEI = 5,  S_WBI   = 6,  S_EXEB  = 7;
    localparam int S_EXEW = 8,  S_MEMLW = 9, S_WBLW  = 10, S_MEMSW = 11;
    localparam int S_WBJAR = 12, S_MULW = 13, S_TRAP = 14;

    logic trigger;
    logic rst;
    multicycle_state_ctrl_if bus ();

    multicycle_state_ctrl #(.MUL_LAT(L), .CNT_W(4)) dut (
        .trigger (trigger),
        .rst     (rst),
        .bus     (bus)
    );

    initial trigger = 1'b0;
    always #5 trigger = ~trigger;

    int n_cmp;
    int n_mis;

    // reference model
    int exp_state;
    int route[$];
    bit cur_is_mul;
    bit exp_mul_start;
    bit exp_instr_done;
    bit exp_illegal;

    logic [5:0] alu_functs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] itype_ops  [8]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expand an instruction into the states visited after ID, up to the return to IF.
    task automatic plan_route(input logic [5:0] o, input logic [5:0] f);
        bit bad;
        route.delete();
        cur_is_mul = 1'b0;
        bad = 1'b0;
        if (o == 6'h00) begin
            if (f inside {alu_functs}) route = '{S_EXER, S_WBR};
            else if (f == 6'h08)       route = '{};
            else                       bad = 1'b1;
        end else if (o inside {itype_ops}) begin
            route = '{S_EXEI, S_WBI};
        end else if (o == 6'h04 || o == 6'h05) begin
            route = '{S_EXEB};
        end else if (o == 6'h23) begin
            route = '{S_EXEW, S_MEMLW, S_WBLW};
        end else if (o == 6'h2B) begin
            route = '{S_EXEW, S_MEMSW};
        end else if (o == 6'h03) begin
            route = '{S_WBJAR};
        end else if (o == 6'h02) begin
            route = '{};
        end else if (o == 6'h1C) begin
            cur_is_mul = 1'b1;
            route.push_back(S_EXER);
            for (int k = 0; k < L; k++) route.push_back(S_MULW);
            route.push_back(S_WBR);
        end else begin
            bad = 1'b1;
        end
`ifdef ISC_TRAP_EN
        if (bad) route = '{S_TRAP};
`else
        if (bad) route = '{};
`endif
    endtask

    // Advance the model across one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit mr, input bit st);
        int prev;
        int nxt;
        prev = exp_state;
        exp_mul_start  = 1'b0;
        exp_instr_done = 1'b0;
        exp_illegal    = 1'b0;
        if (!st) begin
            if (prev == S_INIT) begin
                nxt = S_IF;
            end else if (prev == S_IF) begin
                if (mr) begin
                    plan_route(bus.op, bus.funct);
                    nxt = S_ID;
                end else begin
                    nxt = S_IF;
                end
            end else if ((prev == S_MEMLW || prev == S_MEMSW) && !mr) begin
                nxt = prev;
            end else if (route.size() > 0) begin
                nxt = route.pop_front();
            end else begin
                nxt = S_IF;
            end
            exp_instr_done = (nxt == S_IF) && (prev != S_INIT) && (prev != S_IF) && (prev != S_TRAP);
            exp_mul_start  = (nxt == S_EXER) && cur_is_mul;
            exp_illegal    = (nxt == S_TRAP);
            exp_state      = nxt;
        end
    endtask

    task automatic model_reset();
        exp_state      = S_INIT;
        route.delete();
        cur_is_mul     = 1'b0;
        exp_mul_start  = 1'b0;
        exp_instr_done = 1'b0;
        exp_illegal    = 1'b0;
    endtask

    task automatic pick_instr();
        int kind;
        kind = $urandom_range(0, 14);
        case (kind)
            0:  begin bus.op = 6'h00; bus.funct = 6'h20; end
            1:  begin bus.op = 6'h00; bus.funct = alu_functs[$urandom_range(0, 15)]; end
            2:  begin bus.op = 6'h00; bus.funct = 6'h08; end
            3:  begin bus.op = 6'h00; bus.funct = 6'h01; end
            4:  begin bus.op = 6'h08; bus.funct = 6'($urandom); end
            5:  begin bus.op = itype_ops[$urandom_range(0, 7)]; bus.funct = 6'($urandom); end
            6:  begin bus.op = 6'h04; bus.funct = 6'($urandom); end
            7:  begin bus.op = 6'h05; bus.funct = 6'($urandom); end
            8:  begin bus.op = 6'h23; bus.funct = 6'($urandom); end
            9:  begin bus.op = 6'h2B; bus.funct = 6'($urandom); end
            10: begin bus.op = 6'h03; bus.funct = 6'($urandom); end
            11: begin bus.op = 6'h02; bus.funct = 6'($urandom); end
            12: begin bus.op = 6'h1C; bus.funct = 6'($urandom); end
            13: begin bus.op = 6'h3F; bus.funct = 6'($urandom); end
            default: begin bus.op = 6'($urandom); bus.funct = 6'($urandom); end
        endcase
    endtask

    task automatic check_outputs(input string phase);
        chk({phase, "_state"},      {28'd0, bus.state},      32'(exp_state));
        chk({phase, "_mul_start"},  {31'd0, bus.mul_start},  {31'd0, exp_mul_start});
        chk({phase, "_instr_done"}, {31'd0, bus.instr_done}, {31'd0, exp_instr_done});
        chk({phase, "_illegal"},    {31'd0, bus.illegal},    {31'd0, exp_illegal});
    endtask

    initial begin
        bit mr;
        bit st;
        bit do_rst;
        n_cmp = 0;
        n_mis = 0;
        rst           = 1'b1;
        bus.op        = 6'h00;
        bus.funct     = 6'h00;
        bus.mem_ready = 1'b0;
        bus.stall     = 1'b0;
        model_reset();

        #7;
        check_outputs("reset");
        #1;
        rst = 1'b0;
        check_outputs("reset_release");

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // Instruction register only matters at the IF->ID edge; op/funct stay put afterwards.
            if (exp_state == S_IF) pick_instr();
            mr = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 9) < 2);
            bus.mem_ready = mr;
            bus.stall     = st;
            model_step(mr, st);

            @(posedge trigger);
            #1;
            check_outputs("run");

            if (exp_state == S_MULW || exp_state == S_MEMLW)
                do_rst = ($urandom_range(0, 15) == 0);
            else
                do_rst = ($urandom_range(0, 299) == 0);

            if (do_rst) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(posedge trigger);
                #1;
                rst = 1'b0;
                check_outputs("post_rst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
